// File: rtl/csr_access_unit.sv
// csr_access_unit: requester side of the CSR register-file port.
// Accepts decoded CSR/system ops (CSRRW/CSRRS/CSRRC/ECALL/MRET) from EXU,
// runs the read-modify-write or trap/return sequence against the CSR file
// and returns the old CSR value plus an optional fetch redirect.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req_valid/req_ready         request handshake (ready only while idle)
//   req_op/req_csr_idx/req_src  op code, target CSR, rs1 value or zimm
//   req_src_zero/req_pc         rs1/zimm is zero, PC of the instruction
//   resp_valid/resp_ready       response handshake
//   resp_rdata                  old CSR value for rd
//   redirect_valid/redirect_pc  fetch redirect for ECALL/MRET
//   csrIdx/csrWrEn/csrWrData    CSR file index and write port
//   csrRdData                   CSR file read data (combinational on csrIdx)
//   exception/PC                trap strobe and trapping PC to the CSR file
//   csr_mtvec                   current mtvec
//
// Build option: CSR_ACC_ILLEGAL_TRAP_EN -- when defined, illegal ops (5-7)
// trap like ECALL; otherwise they complete as silent no-ops.

module csr_access_unit #(
  parameter int unsigned       XLEN      = 64,
  parameter int unsigned       CSR_AW    = 12,
  parameter logic [CSR_AW-1:0] MEPC_ADDR = 12'h341
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [CSR_AW-1:0] req_csr_idx,
  input  logic [XLEN-1:0]   req_src,
  input  logic              req_src_zero,
  input  logic [XLEN-1:0]   req_pc,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  output logic [CSR_AW-1:0] csrIdx,
  output logic              csrWrEn,
  output logic [XLEN-1:0]   csrWrData,
  input  logic [XLEN-1:0]   csrRdData,
  output logic              exception,
  output logic [XLEN-1:0]   PC,
  input  logic [XLEN-1:0]   csr_mtvec
);

  localparam logic [2:0] OP_RRW   = 3'd0;
  localparam logic [2:0] OP_RRS   = 3'd1;
  localparam logic [2:0] OP_RRC   = 3'd2;
  localparam logic [2:0] OP_ECALL = 3'd3;
  localparam logic [2:0] OP_MRET  = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e state_q, state_d;

  // Latched request
  logic [2:0]        op_q, op_d;
  logic [CSR_AW-1:0] idx_q, idx_d;
  logic [XLEN-1:0]   src_q, src_d;
  logic              src_zero_q, src_zero_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   old_q, old_d;

  // Registered outputs
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
  logic              redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
  logic [CSR_AW-1:0] csr_idx_q, csr_idx_d;
  logic              wr_en_q, wr_en_d;
  logic [XLEN-1:0]   wr_data_q, wr_data_d;
  logic              exc_q, exc_d;

  // Ops that go through the read-modify-write path
  function automatic logic is_csr_op(input logic [2:0] op);
    return (op == OP_RRW) || (op == OP_RRS) || (op == OP_RRC);
  endfunction

  // Ops that raise a trap toward mtvec
  function automatic logic takes_trap(input logic [2:0] op);
`ifdef CSR_ACC_ILLEGAL_TRAP_EN
    return (op == OP_ECALL) || (op > OP_MRET);
`else
    return (op == OP_ECALL);
`endif
  endfunction

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      op_q             <= '0;
      idx_q            <= '0;
      src_q            <= '0;
      src_zero_q       <= 1'b0;
      pc_q             <= '0;
      old_q            <= '0;
      req_ready_q      <= 1'b1;
      resp_valid_q     <= 1'b0;
      resp_rdata_q     <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      csr_idx_q        <= '0;
      wr_en_q          <= 1'b0;
      wr_data_q        <= '0;
      exc_q            <= 1'b0;
    end else begin
      state_q          <= state_d;
      op_q             <= op_d;
      idx_q            <= idx_d;
      src_q            <= src_d;
      src_zero_q       <= src_zero_d;
      pc_q             <= pc_d;
      old_q            <= old_d;
      req_ready_q      <= req_ready_d;
      resp_valid_q     <= resp_valid_d;
      resp_rdata_q     <= resp_rdata_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      csr_idx_q        <= csr_idx_d;
      wr_en_q          <= wr_en_d;
      wr_data_q        <= wr_data_d;
      exc_q            <= exc_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid) state_d = S_READ;
      S_READ:  state_d = is_csr_op(op_q) ? S_WRITE : S_RESP;
      S_WRITE: state_d = S_RESP;
      S_RESP:  if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; strobes default low so they pulse once
  always_comb begin
    op_d             = op_q;
    idx_d            = idx_q;
    src_d            = src_q;
    src_zero_d       = src_zero_q;
    pc_d             = pc_q;
    old_d            = old_q;
    req_ready_d      = req_ready_q;
    resp_valid_d     = resp_valid_q;
    resp_rdata_d     = resp_rdata_q;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    csr_idx_d        = csr_idx_q;
    wr_en_d          = 1'b0;
    wr_data_d        = wr_data_q;
    exc_d            = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d        = req_op;
          idx_d       = req_csr_idx;
          src_d       = req_src;
          src_zero_d  = req_src_zero;
          pc_d        = req_pc;
          req_ready_d = 1'b0;
          // csrIdx must be valid during READ, so it is chosen at accept
          csr_idx_d   = (req_op == OP_MRET) ? MEPC_ADDR : req_csr_idx;
          exc_d       = takes_trap(req_op);
        end
      end

      S_READ: begin
        old_d = (is_csr_op(op_q) || (op_q == OP_ECALL) || (op_q == OP_MRET))
                ? csrRdData : '0;
        if (is_csr_op(op_q)) begin
          // csrRdData is the value old_q captures this cycle
          wr_en_d = (op_q == OP_RRW) || !src_zero_q;
          case (op_q)
            OP_RRS:  wr_data_d = csrRdData | src_q;
            OP_RRC:  wr_data_d = csrRdData & ~src_q;
            default: wr_data_d = src_q;
          endcase
        end else begin
          resp_valid_d = 1'b1;
          resp_rdata_d = '0;
          if (takes_trap(op_q)) begin
            redirect_valid_d = 1'b1;
            redirect_pc_d    = csr_mtvec;
          end else if (op_q == OP_MRET) begin
            redirect_valid_d = 1'b1;
            redirect_pc_d    = csrRdData;
          end else begin
            redirect_valid_d = 1'b0;
            redirect_pc_d    = '0;
          end
        end
      end

      S_WRITE: begin
        resp_valid_d     = 1'b1;
        resp_rdata_d     = old_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = '0;
      end

      S_RESP: begin
        if (resp_ready) begin
          resp_valid_d     = 1'b0;
          redirect_valid_d = 1'b0;
          req_ready_d      = 1'b1;
        end
      end

      default: ;
    endcase
  end

  // Strobes are masked by reset so an aborted op never writes or traps
  assign csrWrEn        = wr_en_q & ~rst;
  assign exception      = exc_q & ~rst;
  assign PC             = exception ? pc_q : '0;
  assign csrWrData      = wr_data_q;
  assign csrIdx         = csr_idx_q;
  assign req_ready      = req_ready_q;
  assign resp_valid     = resp_valid_q;
  assign resp_rdata     = resp_rdata_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed bench for csr_access_unit with a small CSR-file model
// (mtvec at 0x305, mepc at 0x341, everything else in one scratch register).

module tb_csr_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [11:0] req_csr_idx;
  logic [63:0] req_src;
  logic        req_src_zero;
  logic [63:0] req_pc;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [11:0] csrIdx;
  logic        csrWrEn;
  logic [63:0] csrWrData;
  logic [63:0] csrRdData;
  logic        exception;
  logic [63:0] PC;
  logic [63:0] csr_mtvec;

  logic [63:0] m_mtvec = 64'h0;
  logic [63:0] m_mepc  = 64'h8000_0000;
  logic [63:0] m_other = 64'h0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  csr_access_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_csr_idx(req_csr_idx), .req_src(req_src), .req_src_zero(req_src_zero),
    .req_pc(req_pc),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .csrIdx(csrIdx), .csrWrEn(csrWrEn), .csrWrData(csrWrData),
    .csrRdData(csrRdData), .exception(exception), .PC(PC),
    .csr_mtvec(csr_mtvec)
  );

  // CSR file model: combinational read, write on clock edge
  always_comb begin
    case (csrIdx)
      12'h305: csrRdData = m_mtvec;
      12'h341: csrRdData = m_mepc;
      default: csrRdData = m_other;
    endcase
  end
  assign csr_mtvec = m_mtvec;

  always @(posedge clk) begin
    if (csrWrEn) begin
      case (csrIdx)
        12'h305: m_mtvec <= csrWrData;
        12'h341: m_mepc  <= csrWrData;
        default: m_other <= csrWrData;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Response-side checks, repeated every RESP cycle
  task automatic chk_resp(input string tag, input logic [63:0] exp_rdata,
                          input logic exp_redir, input logic [63:0] exp_rpc);
    chk({tag, ".resp_valid"}, 64'(resp_valid), 64'd1);
    chk({tag, ".resp_rdata"}, resp_rdata, exp_rdata);
    chk({tag, ".redir_valid"}, 64'(redirect_valid), 64'(exp_redir));
    if (exp_redir) chk({tag, ".redir_pc"}, redirect_pc, exp_rpc);
    chk({tag, ".req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, ".wren_resp"}, 64'(csrWrEn), 64'd0);
    chk({tag, ".exc_resp"}, 64'(exception), 64'd0);
  endtask

  // One complete transaction, checked cycle by cycle at negedges
  task automatic run_op(input string tag, input logic [2:0] op, input logic [11:0] idx,
                        input logic [63:0] src, input logic zero, input logic [63:0] pc,
                        input logic [63:0] exp_rdata, input logic exp_wr,
                        input logic [63:0] exp_wdata, input logic exp_trap,
                        input logic exp_redir, input logic [63:0] exp_rpc,
                        input int stall);
    @(negedge clk);
    chk({tag, ".idle_ready"}, 64'(req_ready), 64'd1);
    req_valid    = 1'b1;
    req_op       = op;
    req_csr_idx  = idx;
    req_src      = src;
    req_src_zero = zero;
    req_pc       = pc;
    resp_ready   = (stall == 0);
    @(negedge clk);                       // READ cycle
    req_valid = 1'b0;
    chk({tag, ".rd_idx"}, 64'(csrIdx), 64'((op == 3'd4) ? 12'h341 : idx));
    chk({tag, ".rd_exc"}, 64'(exception), 64'(exp_trap));
    chk({tag, ".rd_pc"}, PC, exp_trap ? pc : 64'h0);
    chk({tag, ".rd_wren"}, 64'(csrWrEn), 64'd0);
    chk({tag, ".rd_ready"}, 64'(req_ready), 64'd0);
    if (op < 3'd3) begin
      @(negedge clk);                     // WRITE cycle
      chk({tag, ".wr_en"}, 64'(csrWrEn), 64'(exp_wr));
      chk({tag, ".wr_data"}, csrWrData, exp_wdata);
      chk({tag, ".wr_exc"}, 64'(exception), 64'd0);
      chk({tag, ".wr_rvalid"}, 64'(resp_valid), 64'd0);
    end
    @(negedge clk);                       // first RESP cycle
    chk_resp(tag, exp_rdata, exp_redir, exp_rpc);
    for (int k = 1; k < stall; k++) begin
      // a request offered while busy must be ignored
      req_valid = 1'b1;
      req_op    = 3'd0;
      @(negedge clk);
      chk_resp({tag, ".hold"}, exp_rdata, exp_redir, exp_rpc);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);                       // back in IDLE after handshake
    chk({tag, ".post_rvalid"}, 64'(resp_valid), 64'd0);
    chk({tag, ".post_redir"}, 64'(redirect_valid), 64'd0);
    chk({tag, ".post_ready"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_op = '0; req_csr_idx = '0; req_src = '0;
    req_src_zero = 1'b0; req_pc = '0; resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.req_ready", 64'(req_ready), 64'd1);
    chk("rst.resp_valid", 64'(resp_valid), 64'd0);
    chk("rst.redir_valid", 64'(redirect_valid), 64'd0);
    chk("rst.wren", 64'(csrWrEn), 64'd0);
    chk("rst.exc", 64'(exception), 64'd0);
    chk("rst.csridx", 64'(csrIdx), 64'd0);
    chk("rst.wdata", csrWrData, 64'd0);
    chk("rst.pc", PC, 64'd0);
    chk("rst.rdata", resp_rdata, 64'd0);
    chk("rst.redir_pc", redirect_pc, 64'd0);
    rst = 1'b0;

    //          tag     op    idx     src            zero pc  rdata          wr  wdata          trap redir rpc  stall
    run_op("rw305",    3'd0, 12'h305, 64'h8000_0100, 0, 64'h0, 64'h0,          1, 64'h8000_0100, 0, 0, 64'h0, 0);
    chk("rw305.mtvec", m_mtvec, 64'h8000_0100);
    run_op("rs305z",   3'd1, 12'h305, 64'h0,         1, 64'h0, 64'h8000_0100,  0, 64'h8000_0100, 0, 0, 64'h0, 0);
    chk("rs305z.mtvec", m_mtvec, 64'h8000_0100);
    run_op("rs341",    3'd1, 12'h341, 64'hF,         0, 64'h0, 64'h8000_0000,  1, 64'h8000_000F, 0, 0, 64'h0, 0);
    run_op("rc341",    3'd2, 12'h341, 64'hF,         0, 64'h0, 64'h8000_000F,  1, 64'h8000_0000, 0, 0, 64'h0, 0);
    chk("rc341.mepc", m_mepc, 64'h8000_0000);
    run_op("rw_tvec",  3'd0, 12'h305, 64'h8000_0200, 0, 64'h0, 64'h8000_0100,  1, 64'h8000_0200, 0, 0, 64'h0, 0);
    // ECALL with 5 cycles of response backpressure
    run_op("ecall",    3'd3, 12'h000, 64'h0,         0, 64'h8000_0040, 64'h0,  0, 64'h0, 1, 1, 64'h8000_0200, 5);
    run_op("rw_mepc",  3'd0, 12'h341, 64'h8000_0044, 0, 64'h0, 64'h8000_0000,  1, 64'h8000_0044, 0, 0, 64'h0, 0);
    run_op("mret",     3'd4, 12'h305, 64'h0,         0, 64'h8000_0050, 64'h0,  0, 64'h0, 0, 1, 64'h8000_0044, 0);
    // CSR-op backpressure keeps a nonzero rdata stable
    run_op("rs_hold",  3'd1, 12'h341, 64'h0,         1, 64'h0, 64'h8000_0044,  0, 64'h8000_0044, 0, 0, 64'h0, 3);
`ifdef CSR_ACC_ILLEGAL_TRAP_EN
    run_op("illegal6", 3'd6, 12'h305, 64'h0,         0, 64'h8000_0060, 64'h0,  0, 64'h0, 1, 1, 64'h8000_0200, 0);
`else
    run_op("illegal6", 3'd6, 12'h305, 64'h0,         0, 64'h8000_0060, 64'h0,  0, 64'h0, 0, 0, 64'h0, 0);
`endif

    // Reset asserted during the WRITE cycle of a CSRRW
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd0; req_csr_idx = 12'h305;
    req_src = 64'hDEAD_BEEF; req_src_zero = 1'b0; resp_ready = 1'b1;
    @(negedge clk);                       // READ
    req_valid = 1'b0;
    @(negedge clk);                       // WRITE
    rst = 1'b1;
    #1;
    chk("abort.wren", 64'(csrWrEn), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("abort.mtvec", m_mtvec, 64'h8000_0200);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort.rvalid", 64'(resp_valid), 64'd0);
      chk("abort.ready", 64'(req_ready), 64'd1);
    end
    run_op("after",    3'd1, 12'h305, 64'h0,         1, 64'h0, 64'h8000_0200,  0, 64'h8000_0200, 0, 0, 64'h0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Strobes must never overlap
  always @(negedge clk) begin
    if (csrWrEn && exception) chk("strobe_overlap", 64'd1, 64'd0);
  end

endmodule
